hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core; sits beside the forwarding logic in the ID/EX boundary.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_sat_counter.sv | 30 +++
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Sequencer states, fixed 3-bit encoding
    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_MWAIT  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Canonical NOP (addi x0,x0,0) loaded by stage flushes
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count requested events, holding once every bit is set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : 5-stage pipeline sequencer: load-use stall, taken-branch
//                flush, data-memory freeze with watchdog, drain/halt control,
//                saturating stall and flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = 4,
    parameter int MAX_WAIT   = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] RS1_ID,
    input  logic [REG_ADDR_W-1:0] RS2_ID,
    input  logic [REG_ADDR_W-1:0] RD_ID_EX,
    input  logic                  mem_read_ID_EX,
    input  logic                  branch_taken_EX,
    input  logic                  dmem_busy,
    input  logic                  drain_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  bubble_mem_wb,
    output logic                  drain_done,
    output logic                  wdog_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [WAIT_W-1:0]  C_WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(PIPE_DEPTH - 1);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic                r_draining;   // MWAIT was entered from DRAIN

    logic                w_load_use;
    logic                w_freeze;
    logic                w_drain_active;
    logic                w_fetch_off;
    logic                w_stall_inc;
    logic                w_flush_inc;
    logic [WAIT_W-1:0]   w_wait_inc;
    state_t              w_mode;

    assign w_load_use = mem_read_ID_EX && (RD_ID_EX != '0) &&
                        ((RD_ID_EX == RS1_ID) || (RD_ID_EX == RS2_ID));
    assign w_wait_inc = r_wait_cnt + 1'b1;
    assign drain_done = (r_state == ST_HALTED);
    assign wdog_err   = (r_state == ST_ERR);

    // Mealy stage controls; MWAIT resumes as whichever mode it interrupted
    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        id_ex_en       = 1'b1;
        ex_mem_en      = 1'b1;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        bubble_mem_wb  = 1'b0;
        w_freeze       = 1'b0;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        w_mode         = r_state;
        if (r_state == ST_MWAIT) begin
            w_mode = r_draining ? ST_DRAIN : ST_RUN;
        end
        w_drain_active = (w_mode == ST_DRAIN) && drain_req;
        w_fetch_off    = w_drain_active || (w_mode == ST_HALTED);

        if (r_state == ST_ERR) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            bubble_mem_wb = 1'b1;
        end else if (dmem_busy && (r_state != ST_HALTED)) begin
            // Whole pipe frozen; EX keeps any branch for re-presentation
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            bubble_mem_wb = 1'b1;
            w_freeze      = 1'b1;
            w_stall_inc   = 1'b1;
        end else begin
            pc_en       = !w_fetch_off;
            flush_if_id = w_drain_active;
            if (branch_taken_EX) begin
                // Any concurrent load-use belongs to the wrong path
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                w_flush_inc = 1'b1;
            end else if (w_load_use) begin
                // Hold the consumer in IF/ID; it must not be replaced by a NOP
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                flush_if_id = 1'b0;
                flush_id_ex = 1'b1;
                w_stall_inc = 1'b1;
            end
        end
    end

    // Sequencer state, memory-wait watchdog and drain progress
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_drain_cnt <= '0;
            r_draining  <= 1'b0;
        end else if (r_state != ST_ERR) begin
            if (w_freeze) begin
                r_wait_cnt <= w_wait_inc;
                r_draining <= (w_mode == ST_DRAIN);
                if (w_wait_inc == C_WAIT_LIMIT) begin
                    r_state <= ST_ERR;
                end else begin
                    r_state <= ST_MWAIT;
                end
            end else begin
                r_wait_cnt <= '0;
                r_draining <= 1'b0;
                case (w_mode)
                    ST_RUN: begin
                        // Drain starts only on a cycle with no other event
                        if (drain_req && !branch_taken_EX && !w_load_use) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= '0;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_DRAIN: begin
                        if (!drain_req) begin
                            r_state     <= ST_RUN;
                            r_drain_cnt <= '0;
                        end else if (r_drain_cnt == C_DRAIN_LAST) begin
                            r_state     <= ST_HALTED;
                            r_drain_cnt <= '0;
                        end else begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= r_drain_cnt + 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        if (!drain_req) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (arst_n),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (arst_n),
        .i_inc (w_flush_inc),
        .o_cnt (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: directed scenarios plus
//                randomized traffic against a behavioural pipeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int RW   = 5;
    localparam int PD   = 4;
    localparam int MW   = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [RW-1:0] rs1, rs2, rd;
    logic          mem_read, br, busy, dreq;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic          flush_if_id, flush_id_ex, bubble_mem_wb, drain_done, wdog_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [8:0]    outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pipeline-level view of what the sequencer is doing
    bit m_err, m_drain, m_halt;
    int m_wait, m_dn, m_stall, m_flush;

    hazard_ctrl #(.REG_ADDR_W(RW), .PIPE_DEPTH(PD), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .arst_n(arst_n),
        .RS1_ID(rs1), .RS2_ID(rs2), .RD_ID_EX(rd),
        .mem_read_ID_EX(mem_read), .branch_taken_EX(br),
        .dmem_busy(busy), .drain_req(dreq),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .bubble_mem_wb(bubble_mem_wb), .drain_done(drain_done), .wdog_err(wdog_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {pc, if_id, id_ex, ex_mem, flush_if_id, flush_id_ex, bubble, drain_done, wdog}
    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex,
                   bubble_mem_wb, drain_done, wdog_err};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at time limit, required finish");
        $fatal(1);
    end

    function automatic bit hazard();
        return mem_read && (rd != 0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // Expected controls from the pipeline rules for the current inputs
    function automatic logic [8:0] model_outs();
        logic pc, ifid, fi, fx, off;
        if (m_err) return 9'b000000101;
        if (busy && !m_halt) return 9'b000000100;
        off  = (m_drain && dreq) || m_halt;
        pc   = !off;
        ifid = 1'b1;
        fi   = m_drain && dreq;
        fx   = 1'b0;
        if (br) begin
            fi = 1'b1;
            fx = 1'b1;
        end else if (hazard()) begin
            pc   = 1'b0;
            ifid = 1'b0;
            fi   = 1'b0;
            fx   = 1'b1;
        end
        return {pc, ifid, 1'b1, 1'b1, fi, fx, 1'b0, m_halt, 1'b0};
    endfunction

    function automatic void model_update();
        if (!arst_n) begin
            m_err = 0; m_drain = 0; m_halt = 0;
            m_wait = 0; m_dn = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (m_err) return;
        if (busy && !m_halt) begin
            m_wait++;
            m_stall = sat(m_stall);
            if (m_wait == MW) m_err = 1;
            return;
        end
        m_wait = 0;
        if (br) m_flush = sat(m_flush);
        else if (hazard()) m_stall = sat(m_stall);
        if (m_halt) begin
            if (!dreq) m_halt = 0;
        end else if (m_drain) begin
            if (!dreq) begin
                m_drain = 0;
                m_dn    = 0;
            end else begin
                m_dn++;
                if (m_dn == PD) begin
                    m_drain = 0;
                    m_halt  = 1;
                    m_dn    = 0;
                end
            end
        end else if (dreq && !br && !hazard()) begin
            m_drain = 1;
            m_dn    = 0;
        end
    endfunction

    task automatic set_in(input logic [RW-1:0] a_rs1, input logic [RW-1:0] a_rs2,
                          input logic [RW-1:0] a_rd, input logic a_mr, input logic a_br,
                          input logic a_busy, input logic a_dreq);
        rs1 = a_rs1; rs2 = a_rs2; rd = a_rd;
        mem_read = a_mr; br = a_br; busy = a_busy; dreq = a_dreq;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        idle();
        tick();
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Dirty the state first: enter a memory wait, then reset mid-wait
        arst_n = 1'b1;
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        do_reset();
        idle();
        n_checks++;
        if (outs !== 9'b111100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required %b", outs, 9'b111100000);
        end
        n_checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got stall=%0d flush=%0d required 0/0", stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== 9'b001101000) begin
            n_fail++;
            $display("FAIL load_use_rs1: got %b required %b", outs, 9'b001101000);
        end
        tick();
        idle();
        n_checks++;
        if (outs !== 9'b111100000 || stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL load_use_after: got %b cnt=%0d required %b cnt=1", outs, stall_cnt, 9'b111100000);
        end
        tick();
        set_in(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== 9'b001101000) begin
            n_fail++;
            $display("FAIL load_use_rs2: got %b required %b", outs, 9'b001101000);
        end
        tick();
        idle();
        n_checks++;
        if (stall_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL load_use_cnt2: got %0d required 2", stall_cnt);
        end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== 9'b111100000) begin
            n_fail++;
            $display("FAIL x0_no_stall: got %b required %b", outs, 9'b111100000);
        end
        tick();
        idle();
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL x0_cnt: got %0d required 0", stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        set_in(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== 9'b111111000) begin
            n_fail++;
            $display("FAIL branch_lu_ctrl: got %b required %b", outs, 9'b111111000);
        end
        tick();
        idle();
        n_checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL branch_lu_cnt: got flush=%0d stall=%0d required 1/0", flush_cnt, stall_cnt);
        end
        tick();
    endtask

    task automatic test_busy_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (outs !== 9'b000000100) begin
                n_fail++;
                $display("FAIL busy_freeze[%0d]: got %b required %b", i, outs, 9'b000000100);
            end
            tick();
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== 9'b111111000) begin
            n_fail++;
            $display("FAIL busy_branch_flush: got %b required %b", outs, 9'b111111000);
        end
        tick();
        idle();
        n_checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL busy_branch_cnt: got stall=%0d flush=%0d required 3/1", stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < MW; i++) begin
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (wdog_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wdog_early[%0d]: got %b required 0", i, wdog_err);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks++;
            if (outs !== 9'b000000101 || stall_cnt !== 4'(CMAX)) begin
                n_fail++;
                $display("FAIL wdog_trip[%0d]: got %b cnt=%0d required %b cnt=%0d",
                         i, outs, stall_cnt, 9'b000000101, CMAX);
            end
            tick();
        end
        do_reset();
        idle();
        n_checks++;
        if (outs !== 9'b111100000) begin
            n_fail++;
            $display("FAIL wdog_clear: got %b required %b", outs, 9'b111100000);
        end
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (outs !== 9'b111100000) begin
            n_fail++;
            $display("FAIL drain_accept: got %b required %b", outs, 9'b111100000);
        end
        tick();
        for (int i = 0; i < PD; i++) begin
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (outs !== 9'b011110000) begin
                n_fail++;
                $display("FAIL drain_cycle[%0d]: got %b required %b", i, outs, 9'b011110000);
            end
            tick();
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (outs !== 9'b011100010) begin
            n_fail++;
            $display("FAIL drain_halted: got %b required %b", outs, 9'b011100010);
        end
        tick();
        idle();
        n_checks++;
        if (outs !== 9'b011100010) begin
            n_fail++;
            $display("FAIL drain_release: got %b required %b", outs, 9'b011100010);
        end
        tick();
        idle();
        n_checks++;
        if (outs !== 9'b111100000) begin
            n_fail++;
            $display("FAIL drain_resume: got %b required %b", outs, 9'b111100000);
        end
        tick();
        // Abandon a drain after one step; a new drain must take the full depth again
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        n_checks++;
        if (outs !== 9'b111100000) begin
            n_fail++;
            $display("FAIL drain_abort: got %b required %b", outs, 9'b111100000);
        end
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < PD; i++) begin
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (drain_done !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_recount[%0d]: got %b required 0", i, drain_done);
            end
            tick();
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (drain_done !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_redone: got %b required 1", drain_done);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) begin
                set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                tick();
            end
            idle();
            n_checks++;
            if (stall_cnt !== ((k == 0) ? 4'd10 : 4'(CMAX))) begin
                n_fail++;
                $display("FAIL sat_stall[%0d]: got %0d required %0d", k, stall_cnt, (k == 0) ? 10 : CMAX);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_o;
        do_reset();
        dreq = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            arst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 11) == 0) dreq = ~dreq;
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0), dreq);
            exp_o = model_outs();
            n_checks++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got %b required %b", i, outs, exp_o);
            end
            n_checks++;
            if (stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
                n_fail++;
                $display("FAIL rand_cnt[%0d]: got stall=%0d flush=%0d required %0d/%0d",
                         i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
            tick();
        end
        arst_n = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0;
        idle();
        tick();
        test_reset();
        test_load_use();
        test_x0();
        test_branch_vs_load_use();
        test_busy_branch();
        test_watchdog();
        test_drain();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
